// File: rtl/vitoria_anim_ctrl.sv
// vitoria_anim_ctrl
// Victory-screen ship animation: after a win pulse the sprite rises from below the
// visible area to a target row, sways horizontally for a fixed number of frames and
// parks. Positions change only at the first clk of vertical blanking, so the renderer
// never sees a mid-frame jump. All outputs are registered.

module vitoria_anim_ctrl #(
   parameter int SCALE       = 6,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int Y_TARGET    = 200,
   parameter int STEP_Y      = 4,
   parameter int STEP_X      = 2,
   parameter int X_MIN       = 40,
   parameter int X_MAX       = 534,
   parameter int HOLD_FRAMES = 180
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] h_counter,
   input  logic [9:0] v_counter,
   input  logic       start,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       active,
   output logic       done
);

   localparam int FCW = $clog2(HOLD_FRAMES + 1);

   localparam logic [9:0]     P_X_CENTER = 10'((H_ACTIVE - 11 * SCALE) / 2);
   localparam logic [9:0]     P_V_ACTIVE = 10'(V_ACTIVE);
   localparam logic [9:0]     P_Y_TARGET = 10'(Y_TARGET);
   localparam logic [9:0]     P_STEP_Y   = 10'(STEP_Y);
   localparam logic [9:0]     P_STEP_X   = 10'(STEP_X);
   localparam logic [9:0]     P_X_MIN    = 10'(X_MIN);
   localparam logic [9:0]     P_X_MAX    = 10'(X_MAX);
   localparam logic [FCW-1:0] P_CNT_LAST = FCW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RISE,
      S_SWAY,
      S_DONE
   } state_t;

   // dir: 0 = moving right, 1 = moving left
   state_t         r_state,     w_state_nxt;
   logic [9:0]     r_pos_x,     w_pos_x_nxt;
   logic [9:0]     r_pos_y,     w_pos_y_nxt;
   logic           r_dir,       w_dir_nxt;
   logic [FCW-1:0] r_frame_cnt, w_frame_cnt_nxt;
   logic           r_active;
   logic           r_done;
   logic           r_cond_q;
   logic           w_cond;
   logic           w_tick;

   // One-clk frame tick on the rising edge of "first blanking pixel", so a clk faster
   // than the pixel clock still produces exactly one update per frame.
   assign w_cond = (h_counter == 10'd0) && (v_counter == P_V_ACTIVE);
   assign w_tick = w_cond & ~r_cond_q;

   assign pos_x  = r_pos_x;
   assign pos_y  = r_pos_y;
   assign active = r_active;
   assign done   = r_done;

   // State register and registered outputs; synchronous reset wins over everything.
   // NOTE: sequential state uses non-blocking (<=) so every register samples the
   // pre-edge values and the block order does not matter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pos_x     <= P_X_CENTER;
         r_pos_y     <= P_V_ACTIVE;
         r_dir       <= 1'b0;
         r_frame_cnt <= '0;
         r_active    <= 1'b0;
         r_done      <= 1'b0;
         r_cond_q    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pos_x     <= w_pos_x_nxt;
         r_pos_y     <= w_pos_y_nxt;
         r_dir       <= w_dir_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_active    <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         r_cond_q    <= w_cond;
      end
   end

   // Next-state and next-position logic for the rise / sway / park sequence.
   // NOTE: every signal assigned here gets a hold default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt     = r_state;
      w_pos_x_nxt     = r_pos_x;
      w_pos_y_nxt     = r_pos_y;
      w_dir_nxt       = r_dir;
      w_frame_cnt_nxt = r_frame_cnt;

      case (r_state)
         S_IDLE, S_DONE: begin
            // A tick coinciding with start is deliberately not applied here.
            if (start) begin
               w_state_nxt = S_RISE;
               w_pos_x_nxt = P_X_CENTER;
               w_pos_y_nxt = P_V_ACTIVE;
            end
         end

         S_RISE: begin
            if (w_tick) begin
               // Compare the remaining distance before subtracting so pos_y never
               // drops below the target.
               if (({1'b0, r_pos_y} - {1'b0, P_Y_TARGET}) <= {1'b0, P_STEP_Y}) begin
                  w_pos_y_nxt     = P_Y_TARGET;
                  w_state_nxt     = S_SWAY;
                  w_frame_cnt_nxt = '0;
                  w_dir_nxt       = 1'b0;
               end else begin
                  w_pos_y_nxt = r_pos_y - P_STEP_Y;
               end
            end
         end

         S_SWAY: begin
            if (w_tick) begin
               w_frame_cnt_nxt = r_frame_cnt + 1'b1;
               // Reaching or passing a bound clamps to it and reverses direction.
               if (!r_dir) begin
                  if (({1'b0, r_pos_x} + {1'b0, P_STEP_X}) >= {1'b0, P_X_MAX}) begin
                     w_pos_x_nxt = P_X_MAX;
                     w_dir_nxt   = 1'b1;
                  end else begin
                     w_pos_x_nxt = r_pos_x + P_STEP_X;
                  end
               end else begin
                  if ({1'b0, r_pos_x} <= ({1'b0, P_X_MIN} + {1'b0, P_STEP_X})) begin
                     w_pos_x_nxt = P_X_MIN;
                     w_dir_nxt   = 1'b0;
                  end else begin
                     w_pos_x_nxt = r_pos_x - P_STEP_X;
                  end
               end
               if (r_frame_cnt == P_CNT_LAST) begin
                  w_state_nxt = S_DONE;
               end
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_vitoria_anim_ctrl.sv
// tb_vitoria_anim_ctrl
// Self-checking bench: each frame of stimulus pushes the expected
// {active, done, pos_x, pos_y} onto a scoreboard queue, which is popped and
// compared against the DUT once the frame's update has been registered.

module tb_vitoria_anim_ctrl;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       start     = 1'b0;
   logic [9:0] h_counter = 10'd5;
   logic [9:0] v_counter = 10'd10;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       active;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [21:0] exp;
   } sb_t;

   sb_t sb_q[$];

   always #5 clk = ~clk;

   vitoria_anim_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .h_counter (h_counter),
      .v_counter (v_counter),
      .start     (start),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .active    (active),
      .done      (done)
   );

   task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got act=%0b done=%0b x=%0d y=%0d, expected act=%0b done=%0b x=%0d y=%0d",
                  tag, got[21], got[20], got[19:10], got[9:0],
                  exp[21], exp[20], exp[19:10], exp[9:0]);
      end
   endtask

   function automatic logic [21:0] pack(input int x, input int y, input bit a, input bit d);
      return {a, d, 10'(x), 10'(y)};
   endfunction

   // Horizontal position after s sway ticks, bouncing between 40 and 534.
   function automatic int bounce(input int s);
      int x;
      int dir;
      x   = 287;
      dir = 1;
      for (int i = 0; i < s; i++) begin
         x = x + 2 * dir;
         if (dir > 0 && x >= 534) begin
            x   = 534;
            dir = -1;
         end else if (dir < 0 && x <= 40) begin
            x   = 40;
            dir = 1;
         end
      end
      return x;
   endfunction

   // Expected outputs n ticks after a start: 70 rise ticks, then 180 sway ticks, then parked.
   function automatic logic [21:0] model(input int n);
      int s;
      int y;
      s = (n > 70) ? n - 70 : 0;
      if (s > 180) s = 180;
      y = (n >= 70) ? 200 : 480 - 4 * n;
      return pack(bounce(s), y, 1'b1, s == 180);
   endfunction

   task automatic push(input string tag, input logic [21:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.tag, {active, done, pos_x, pos_y}, e.exp);
      end
   endtask

   // One frame: first blanking pixel held for mult clks, optional start in its first clk.
   task automatic frame(input int mult, input bit with_start);
      @(negedge clk);
      h_counter = 10'd0;
      v_counter = 10'd480;
      start     = with_start;
      @(negedge clk);
      start = 1'b0;
      repeat (mult - 1) @(negedge clk);
      h_counter = 10'd1;
      repeat (2) @(negedge clk);
      h_counter = 10'd5;
      v_counter = 10'd10;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push("reset", pack(287, 480, 1'b0, 1'b0));
      drain();

      for (int i = 0; i < 3; i++) begin
         frame(1, 1'b0);
         push("idle", pack(287, 480, 1'b0, 1'b0));
         drain();
      end

      // Start arrives in the same clk as a tick: ship must not move yet.
      frame(1, 1'b1);
      push("start_tick", model(0));
      drain();

      for (int n = 1; n <= 250; n++) begin
         frame((n % 10 == 0) ? 4 : 1, 1'b0);
         push((n <= 70) ? "rise" : "sway", model(n));
         if (n == 70)  push("at_target", pack(287, 200, 1'b1, 1'b0));
         if (n == 194) push("clamp_max", pack(534, 200, 1'b1, 1'b0));
         if (n == 196) push("after_clamp", pack(530, 200, 1'b1, 1'b0));
         if (n == 250) push("done", pack(422, 200, 1'b1, 1'b1));
         drain();
      end

      for (int i = 0; i < 3; i++) begin
         frame(4, 1'b0);
         push("frozen", pack(422, 200, 1'b1, 1'b1));
         drain();
      end

      // Restart from DONE, again coinciding with a tick.
      frame(1, 1'b1);
      push("restart", pack(287, 480, 1'b1, 1'b0));
      drain();

      for (int n = 1; n <= 45; n++) begin
         frame(1, 1'b0);
         push("rise2", model(n));
         drain();
      end
      push("y300", pack(287, 300, 1'b1, 1'b0));
      drain();

      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      push("mid_reset", pack(287, 480, 1'b0, 1'b0));
      drain();

      frame(1, 1'b0);
      push("idle_after_reset", pack(287, 480, 1'b0, 1'b0));
      drain();

      pulse_start();
      push("start", model(0));
      drain();

      for (int n = 1; n <= 80; n++) begin
         if (n == 75) pulse_start();
         frame((n % 7 == 0) ? 4 : 1, n == 78);
         push((n <= 70) ? "rise3" : "sway_start_ignored", model(n));
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
